apb_slave_mux_n: RTL

- Parametrised APB fan-out stage: one upstream APB requester (bridge slave side) to N_SLV downstream APB completers, all on b_pclk.
- Decodes the top SEL_WD address bits to a slave index and latches it for the whole transfer.
- Returns PSLVERR for unmapped indices and for protocol violations.
- Aborts hung slaves with a timeout error when `APB_MUX_TIMEOUT_EN` is compiled in.

---
 rtl/apb_slave_mux_n_pkg.sv | 26 ++
 rtl/apb_slave_mux_n_if.sv | 47 ++++
 rtl/apb_slave_mux_n_tmo_cnt.sv | 39 +++
 rtl/apb_slave_mux_n.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/apb_slave_mux_n_pkg.sv
// rtl/apb_slave_mux_n_pkg.sv - shared state encoding, decode helper and default widths for the APB fan-out
package apb_mux_pkg;

  localparam int N_SLV_DEF   = 4;
  localparam int SEL_WD_DEF  = 2;
  localparam int ADDR_WD_DEF = 32;
  localparam int DATA_WD_DEF = 32;
  localparam int STRB_WD_DEF = 4;
  localparam int PROT_WD_DEF = 3;
  localparam int TMO_CYC_DEF = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } apb_mux_state_e;

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_ERR    = ERR;

  function automatic logic idx_mapped(input int idx, input int n_slv);
    return idx < n_slv;
  endfunction

endpackage

// File: rtl/apb_slave_mux_n_if.sv
// rtl/apb_slave_mux_n_if.sv - upstream APB port plus N-way downstream APB bundle of the fan-out stage
interface apb_slave_mux_n_if #(
  parameter int N_SLV   = 4,
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32,
  parameter int STRB_WD = 4,
  parameter int PROT_WD = 3
);

  logic                     b_psel;
  logic                     b_penable;
  logic                     b_pwrite;
  logic [ADDR_WD-1:0]       b_paddr;
  logic [DATA_WD-1:0]       b_pwdata;
  logic [PROT_WD-1:0]       b_pprot;
  logic [STRB_WD-1:0]       b_pstrb;
  logic [DATA_WD-1:0]       b_prdata;
  logic                     b_pready;
  logic                     b_pslverr;

  logic [N_SLV-1:0]         m_psel;
  logic                     m_penable;
  logic                     m_pwrite;
  logic [ADDR_WD-1:0]       m_paddr;
  logic [DATA_WD-1:0]       m_pwdata;
  logic [PROT_WD-1:0]       m_pprot;
  logic [STRB_WD-1:0]       m_pstrb;
  logic [N_SLV*DATA_WD-1:0] m_prdata;
  logic [N_SLV-1:0]         m_pready;
  logic [N_SLV-1:0]         m_pslverr;

  // The mux is the completer toward the bridge and the requester toward the slaves.
  modport slave (
    input  b_psel, b_penable, b_pwrite, b_paddr, b_pwdata, b_pprot, b_pstrb,
    output b_prdata, b_pready, b_pslverr,
    output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pprot, m_pstrb,
    input  m_prdata, m_pready, m_pslverr
  );

  modport master (
    output b_psel, b_penable, b_pwrite, b_paddr, b_pwdata, b_pprot, b_pstrb,
    input  b_prdata, b_pready, b_pslverr,
    input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pprot, m_pstrb,
    output m_prdata, m_pready, m_pslverr
  );

endinterface

// File: rtl/apb_slave_mux_n_tmo_cnt.sv
// rtl/apb_slave_mux_n_tmo_cnt.sv - access-phase wait counter that raises an abort once TMO_CYC waits have elapsed
module apb_mux_tmo_cnt #(
  parameter int TMO_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic abort_o
);

  localparam int CNT_WD = $clog2(TMO_CYC + 1);
  localparam logic [CNT_WD-1:0] CNT_MAX = CNT_WD'(TMO_CYC);

  logic [CNT_WD-1:0] cnt_q, cnt_d;
  logic              at_max;

  assign at_max  = (cnt_q == CNT_MAX);
  // Abort only on a still-waiting cycle; a ready in the same cycle masks en_i upstream.
  assign abort_o = en_i && at_max;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !at_max) begin
      cnt_d = cnt_q + CNT_WD'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_slave_mux_n.sv
// rtl/apb_slave_mux_n.sv - APB 1:N fan-out with latched slave decode; APB_MUX_TIMEOUT_EN adds hung-slave abort
module apb_slave_mux_n
  import apb_mux_pkg::*;
#(
  parameter int N_SLV   = N_SLV_DEF,
  parameter int SEL_WD  = SEL_WD_DEF,
  parameter int ADDR_WD = ADDR_WD_DEF,
  parameter int DATA_WD = DATA_WD_DEF,
  parameter int STRB_WD = STRB_WD_DEF,
  parameter int PROT_WD = PROT_WD_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic             b_pclk,
  input  logic             b_prst,
  apb_slave_mux_n_if.slave bus
);

  if (N_SLV < 1 || N_SLV > 16 || (1 << SEL_WD) < N_SLV || TMO_CYC < 1) begin : g_bad_cfg
    $error("apb_slave_mux_n: illegal parameter set");
  end

  logic [1:0]         state_q, state_d;
  logic [SEL_WD-1:0]  sel_q, sel_d;
  logic               map_q, map_d;

  logic [SEL_WD-1:0]  idx;
  logic               mapped;
  logic               in_access;
  logic               slv_rdy;
  logic               slv_err;
  logic [DATA_WD-1:0] slv_rdata;
  logic               tmo_abort;

  logic [N_SLV-1:0]   psel;
  logic               penable;
  logic               pready;
  logic               pslverr;
  logic [DATA_WD-1:0] prdata;

  assign idx    = bus.b_paddr[ADDR_WD-1 -: SEL_WD];
  assign mapped = idx_mapped(int'(idx), N_SLV);

  // Response mux keyed on the latched index so upstream address changes mid-transfer are ignored.
  assign in_access = (state_q == ST_ACCESS) && map_q;
  assign slv_rdy   = bus.m_pready[sel_q];
  assign slv_err   = bus.m_pslverr[sel_q];
  assign slv_rdata = bus.m_prdata[sel_q*DATA_WD +: DATA_WD];

`ifdef APB_MUX_TIMEOUT_EN
  apb_mux_tmo_cnt #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo (
    .clk_i   (b_pclk),
    .rst_i   (b_prst),
    .clr_i   (!in_access),
    .en_i    (in_access && bus.b_psel && bus.b_penable && !slv_rdy),
    .abort_o (tmo_abort)
  );
`else
  assign tmo_abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    map_d   = map_q;
    psel    = '0;
    penable = 1'b0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.b_psel && !bus.b_penable) begin
          sel_d = idx;
          map_d = mapped;
          if (mapped) begin
            psel[idx] = 1'b1;
            state_d   = ST_ACCESS;
          end else begin
            state_d = ST_ERR;
          end
        end else if (bus.b_psel && bus.b_penable) begin
          // Enable without a setup phase: error it out locally, never reach a slave.
          pready  = 1'b1;
          pslverr = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!bus.b_psel || !map_q) begin
          state_d = ST_IDLE;
        end else begin
          psel[sel_q] = 1'b1;
          penable     = bus.b_penable;
          if (slv_rdy) begin
            pready  = 1'b1;
            pslverr = slv_err;
            prdata  = slv_rdata;
            state_d = ST_IDLE;
          end else if (tmo_abort) begin
            pready  = 1'b1;
            pslverr = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_ERR: begin
        if (bus.b_psel) begin
          pready  = 1'b1;
          pslverr = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge b_pclk) begin
    if (b_prst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      map_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      map_q   <= map_d;
    end
  end

  assign bus.m_psel    = psel;
  assign bus.m_penable = penable;
  assign bus.m_pwrite  = bus.b_pwrite;
  assign bus.m_paddr   = bus.b_paddr;
  assign bus.m_pwdata  = bus.b_pwdata;
  assign bus.m_pprot   = bus.b_pprot;
  assign bus.m_pstrb   = bus.b_pstrb;

  assign bus.b_pready  = pready;
  assign bus.b_pslverr = pslverr;
  assign bus.b_prdata  = prdata;

endmodule
